// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
//
// Per-output-port switch allocator sitting directly behind the router input
// units. Each input unit raises a switch request together with its computed
// route. Every output port runs its own round-robin arbiter over the inputs
// routed to it. The winner gets a one-cycle ack and the output stays locked to
// it until that input reports its tail flit. The lock state drives the crossbar
// select and valid lines.
//
// Handshake: i_switch_req[i] is a level request that is qualified by i_route
// slice i. It is sampled on every rising edge. The grant is o_switch_ack[i],
// a registered pulse that lasts exactly one cycle. A requester that keeps its
// request high while it owns a lock is not acked again. i_packet_done[i] is
// honoured only when input i currently owns an output.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   i_switch_req   [NUM_PORTS]            per-input switch request
//   i_route        [NUM_PORTS*ROUTE_W]    flattened routes (MSB=1 -> invalid)
//   i_packet_done  [NUM_PORTS]            per-input tail-flit indication
//   o_switch_ack   [NUM_PORTS]            one-cycle grant pulse per input
//   o_xbar_sel     [NUM_PORTS*PORT_BITS]  slice o = input driving output o
//   o_out_valid    [NUM_PORTS]            output o is locked to an input
//
// The per-output FSM state register is brought out directly on o_out_valid
// (LOCKED = 1). Debug probes therefore see the FSM state with no extra port.
// All outputs come straight from flops, so no combinational path runs from
// any input to any output.
// -----------------------------------------------------------------------------
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_BITS = $clog2(NUM_PORTS),
  parameter int ROUTE_W   = PORT_BITS + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           i_switch_req,
  input  logic [NUM_PORTS*ROUTE_W-1:0]   i_route,
  input  logic [NUM_PORTS-1:0]           i_packet_done,
  output logic [NUM_PORTS-1:0]           o_switch_ack,
  output logic [NUM_PORTS*PORT_BITS-1:0] o_xbar_sel,
  output logic [NUM_PORTS-1:0]           o_out_valid
);

  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Per-output registered state
  logic [0:0]           state_q [NUM_PORTS];
  logic [PORT_BITS-1:0] owner_q [NUM_PORTS];
  logic [PORT_BITS-1:0] rr_q    [NUM_PORTS];
  logic [NUM_PORTS-1:0] ack_q;

  logic [0:0]           state_d [NUM_PORTS];
  logic [PORT_BITS-1:0] owner_d [NUM_PORTS];
  logic [PORT_BITS-1:0] rr_d    [NUM_PORTS];
  logic [NUM_PORTS-1:0] ack_d;

  // Request decode and arbitration
  logic [NUM_PORTS-1:0] input_busy;
  logic [NUM_PORTS-1:0] req_ok;
  logic [PORT_BITS-1:0] route_dst [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig      [NUM_PORTS];  // elig[o][i]
  logic [NUM_PORTS-1:0] win_found;
  logic [PORT_BITS-1:0] win_idx   [NUM_PORTS];

  // (base + offset) mod NUM_PORTS. Both operands are already below
  // NUM_PORTS, so a single conditional subtract is enough.
  function automatic logic [PORT_BITS-1:0] wrap_idx(
    input logic [PORT_BITS-1:0] base,
    input int                   offset
  );
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[PORT_BITS-1:0];
  endfunction

  // An input that owns a lock may not compete. This stops a requester that
  // holds its request from winning a second time.
  always_comb begin
    input_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == ST_LOCKED) input_busy[owner_q[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route_dst[i] = i_route[i*ROUTE_W +: PORT_BITS];
      req_ok[i]    = i_switch_req[i] && !i_route[i*ROUTE_W + PORT_BITS] && !input_busy[i];
    end
  end

  // Destinations of NUM_PORTS or more never match a real output index, so
  // those requests drop out here without any extra check.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      elig[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig[o][i] = req_ok[i] && (route_dst[i] == PORT_BITS'(o)) && (state_q[o] == ST_FREE);
      end
    end
  end

  // Round-robin pick: the first eligible index at or after rr_q[o], with wrap.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_found[o] = 1'b0;
      win_idx[o]   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!win_found[o] && elig[o][wrap_idx(rr_q[o], k)]) begin
          win_found[o] = 1'b1;
          win_idx[o]   = wrap_idx(rr_q[o], k);
        end
      end
    end
  end

  // Next state. A release is evaluated only in LOCKED, so an output never
  // re-grants on the same edge that frees it.
  always_comb begin
    ack_d = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      if (state_q[o] == ST_LOCKED) begin
        if (i_packet_done[owner_q[o]]) state_d[o] = ST_FREE;
      end else if (win_found[o]) begin
        state_d[o]          = ST_LOCKED;
        owner_d[o]          = win_idx[o];
        rr_d[o]             = (win_idx[o] == PORT_BITS'(NUM_PORTS - 1)) ? '0 : win_idx[o] + 1'b1;
        ack_d[win_idx[o]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= ST_FREE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      ack_q <= ack_d;
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  // The owner register doubles as the crossbar select. It keeps its last
  // value while the output is FREE.
  always_comb begin
    o_switch_ack = ack_q;
    o_out_valid  = '0;
    o_xbar_sel   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      o_out_valid[o]                       = (state_q[o] == ST_LOCKED);
      o_xbar_sel[o*PORT_BITS +: PORT_BITS] = owner_q[o];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator
//
// Directed testbench for switch_allocator with NUM_PORTS=5, which gives
// 3-bit port indices and 4-bit routes. Inputs are driven 1 time unit after
// each rising edge, and outputs are sampled at that same point. Values
// driven before edge t are therefore observed in cycle t+1.
// -----------------------------------------------------------------------------
module tb_switch_allocator;

  localparam int N  = 5;
  localparam int PB = 3;
  localparam int RW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req;
  logic [N*RW-1:0] route;
  logic [N-1:0]    done;
  logic [N-1:0]    ack;
  logic [N*PB-1:0] xbar;
  logic [N-1:0]    valid;

  switch_allocator #(.NUM_PORTS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_switch_req  (req),
    .i_route       (route),
    .i_packet_done (done),
    .o_switch_ack  (ack),
    .o_xbar_sel    (xbar),
    .o_out_valid   (valid)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_route(input int i, input logic [RW-1:0] r);
    route[i*RW +: RW] = r;
  endtask

  function automatic logic [PB-1:0] sel(input int o);
    return xbar[o*PB +: PB];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    req   = '0;
    route = '0;
    done  = '0;
    step();
    step();
    check_eq("rst_ack",   32'(ack),   32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_xbar",  32'(xbar),  32'h0);
    reset = 1'b0;

    // --- Input 2 -> output 3, held request, non-owner done, release ---
    req[2] = 1'b1;
    set_route(2, 4'b0011);
    step();
    check_eq("t1_ack",   32'(ack),    32'h04);
    check_eq("t1_valid", 32'(valid),  32'h08);
    check_eq("t1_sel3",  32'(sel(3)), 32'd2);
    step();
    check_eq("t1_ack_once", 32'(ack), 32'h0);
    step();
    check_eq("t1_held_noack", 32'(ack),   32'h0);
    check_eq("t1_held_valid", 32'(valid), 32'h08);
    done[1] = 1'b1;                       // non-owner done is ignored
    step();
    check_eq("t1_nonowner_valid", 32'(valid), 32'h08);
    done[1] = 1'b0;
    done[2] = 1'b1;
    req[2]  = 1'b0;
    step();
    check_eq("t1_rel_valid", 32'(valid),  32'h0);
    check_eq("t1_rel_sel3",  32'(sel(3)), 32'd2);
    done[2] = 1'b0;

    // --- Inputs 0 and 4 -> output 1, round-robin with wrap ---
    req[0] = 1'b1; set_route(0, 4'b0001);
    req[4] = 1'b1; set_route(4, 4'b0001);
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b00001);
    step();
    check_eq("t2_ack_first", 32'(ack), 32'(exp_q.pop_front()));
    check_eq("t2_sel1_0",    32'(sel(1)), 32'd0);
    step();
    check_eq("t2_blocked", 32'(ack), 32'h0);
    done[0] = 1'b1;
    req[0]  = 1'b0;
    step();
    check_eq("t2_rel_valid", 32'(valid), 32'h0);
    check_eq("t2_rel_noack", 32'(ack),   32'h0);
    done[0] = 1'b0;
    step();
    check_eq("t2_ack_second", 32'(ack), 32'(exp_q.pop_front()));
    check_eq("t2_sel1_4",     32'(sel(1)), 32'd4);
    req[0]  = 1'b1;                        // both compete again; rr_ptr wrapped to 0
    done[4] = 1'b1;
    step();
    check_eq("t2_rel4_valid", 32'(valid), 32'h0);
    done[4] = 1'b0;
    step();
    check_eq("t2_ack_wrap", 32'(ack), 32'(exp_q.pop_front()));
    req     = '0;
    done[0] = 1'b1;
    step();
    done    = '0;
    check_eq("t2_idle_valid", 32'(valid), 32'h0);

    // --- Invalid route and out-of-range port are never acked ---
    req[1] = 1'b1; set_route(1, 4'b1000);
    req[3] = 1'b1; set_route(3, 4'b0110);
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq($sformatf("t3_ack_c%0d", c),   32'(ack),   32'h0);
      check_eq($sformatf("t3_valid_c%0d", c), 32'(valid), 32'h0);
    end
    req = '0;

    // --- Parallel grants: 0->2, 1->3, 3->4 ---
    req[0] = 1'b1; set_route(0, 4'b0010);
    req[1] = 1'b1; set_route(1, 4'b0011);
    req[3] = 1'b1; set_route(3, 4'b0100);
    step();
    check_eq("t4_ack",   32'(ack),    32'h0B);
    check_eq("t4_valid", 32'(valid),  32'h1C);
    check_eq("t4_sel2",  32'(sel(2)), 32'd0);
    check_eq("t4_sel3",  32'(sel(3)), 32'd1);
    check_eq("t4_sel4",  32'(sel(4)), 32'd3);
    req  = '0;
    done = 5'b01011;
    step();
    check_eq("t4_rel_valid", 32'(valid), 32'h0);
    done = '0;

    // --- Simultaneous release and request, then single-flit packet ---
    req[2] = 1'b1; set_route(2, 4'b0011);
    step();
    check_eq("t5_lock_ack", 32'(ack), 32'h04);
    req[2]  = 1'b0;
    done[2] = 1'b1;
    req[1]  = 1'b1; set_route(1, 4'b0011);
    step();
    check_eq("t5_rel_valid", 32'(valid), 32'h0);
    check_eq("t5_rel_noack", 32'(ack),   32'h0);
    done[2] = 1'b0;
    step();
    check_eq("t5_late_ack", 32'(ack),    32'h02);
    check_eq("t5_sel3",     32'(sel(3)), 32'd1);
    req[1]  = 1'b0;
    done[1] = 1'b1;                        // tail flit in the ack cycle
    step();
    check_eq("t5_single_flit_valid", 32'(valid), 32'h0);
    done[1] = 1'b0;

    // --- Reset between edges while a lock and an ack are live ---
    req[0] = 1'b1; set_route(0, 4'b0010);
    step();
    check_eq("t6_pre_ack", 32'(ack), 32'h01);
    req = '0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_async_ack",   32'(ack),   32'h0);
    check_eq("t6_async_valid", 32'(valid), 32'h0);
    check_eq("t6_async_xbar",  32'(xbar),  32'h0);
    step();
    reset = 1'b0;
    req[0] = 1'b1; set_route(0, 4'b0010);
    req[3] = 1'b1; set_route(3, 4'b0010);
    step();
    check_eq("t6_rr_ack",  32'(ack),    32'h01);
    check_eq("t6_rr_sel2", 32'(sel(2)), 32'd0);
    req = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
